// File: rtl/ace_write_arbiter.sv
// ace_write_arbiter: round-robin owner of the shared AW+W write path.
// One owner holds the path for one AW beat plus BEATS W beats.
// Ports:
//   s_aw*/s_w*  per-CPU write-back/evict requests (flat, port p at slot p)
//   m_aw*/m_w*  single downstream AXI/ACE AW and W channels
//   grant       one-hot current owner, 0 when idle
//   err         sticky flag: requester WLAST disagreed with generated WLAST
module ace_write_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int PORT_W    = 2,
  parameter int MSHR_ID_W = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             s_awvalid,
  output logic [N_PORTS-1:0]             s_awready,
  input  logic [N_PORTS*MSHR_ID_W-1:0]   s_awid,
  input  logic [N_PORTS*ADDR_W-1:0]      s_awaddr,
  input  logic [N_PORTS*3-1:0]           s_awsnoop,
  input  logic [N_PORTS-1:0]             s_wvalid,
  output logic [N_PORTS-1:0]             s_wready,
  input  logic [N_PORTS*DATA_W-1:0]      s_wdata,
  input  logic [N_PORTS-1:0]             s_wlast,
  output logic                           m_awvalid,
  input  logic                           m_awready,
  output logic [MSHR_ID_W+PORT_W-1:0]    m_awid,
  output logic [ADDR_W-1:0]              m_awaddr,
  output logic [2:0]                     m_awsnoop,
  output logic [7:0]                     m_awlen,
  output logic [2:0]                     m_awsize,
  output logic [1:0]                     m_awburst,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  output logic [DATA_W-1:0]              m_wdata,
  output logic                           m_wlast,
  output logic [N_PORTS-1:0]             grant,
  output logic                           err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PORT_W-1:0] TOP_PORT = PORT_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W
  } state_t;

  state_t            state_q, state_d;
  logic [PORT_W-1:0] sel_q, sel_d;
  logic [PORT_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              err_q, err_d;

  logic [PORT_W-1:0] win;
  logic [PORT_W-1:0] idx;
  logic              found;
  logic              last;

  logic [MSHR_ID_W-1:0] id_a    [N_PORTS];
  logic [ADDR_W-1:0]    addr_a  [N_PORTS];
  logic [2:0]           snoop_a [N_PORTS];
  logic [DATA_W-1:0]    data_a  [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign id_a[p]    = s_awid[p*MSHR_ID_W +: MSHR_ID_W];
    assign addr_a[p]  = s_awaddr[p*ADDR_W +: ADDR_W];
    assign snoop_a[p] = s_awsnoop[p*3 +: 3];
    assign data_a[p]  = s_wdata[p*DATA_W +: DATA_W];
  end

  // Scan rr_q, rr_q+1, ... and keep the first requester seen.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = PORT_W'((int'(rr_q) + i) % N_PORTS);
      if (!found && s_awvalid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Payload follows the frozen owner, so it cannot move under m_awvalid.
  assign m_awid    = {id_a[sel_q], sel_q};
  assign m_awaddr  = addr_a[sel_q];
  assign m_awsnoop = snoop_a[sel_q];
  assign m_wdata   = data_a[sel_q];
  assign m_awlen   = 8'(BEATS - 1);
  assign m_awsize  = 3'($clog2(DATA_W / 8));
  assign m_awburst = 2'b01;
  assign err       = err_q;
  assign last      = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    err_d     = err_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    grant     = '0;
    unique case (state_q)
      IDLE: begin
        if (|s_awvalid) begin
          sel_d   = win;
          state_d = AW;
        end
      end
      AW: begin
        m_awvalid        = 1'b1;
        grant[sel_q]     = 1'b1;
        s_awready[sel_q] = m_awready;
        if (m_awready) begin
          beat_d  = '0;
          rr_d    = (sel_q == TOP_PORT) ? '0 : sel_q + 1'b1;
          state_d = W;
        end
      end
      W: begin
        grant[sel_q]    = 1'b1;
        m_wvalid        = s_wvalid[sel_q];
        s_wready[sel_q] = m_wready;
        m_wlast         = last;
        if (s_wvalid[sel_q] && m_wready) begin
          // Burst length comes from beat_q only; s_wlast is just audited.
          if (s_wlast[sel_q] != last) err_d = 1'b1;
          if (last) state_d = IDLE;
          else      beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule
